// File: rtl/coin_pulse_conditioner.sv
// ---------------------------------------------------------------------------
// coin_pulse_conditioner
//
// Purpose:
//   Front end of the vending machine. It takes the three raw, asynchronous and
//   bouncing coin-sensor lines and produces clean, mutually exclusive,
//   single-cycle coin pulses for the vending FSM. The block does four jobs:
//     - It rejects ambiguous multi-sensor events.
//     - It guarantees at most one pulse per physical coin.
//     - It requires a full release before another coin is accepted.
//     - It enforces a lockout gap between consecutive pulses.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable synchronized cycles needed for press and release (>= 2)
//   LOCKOUT_CYCLES   dead time after a confirmed release (>= 1)
//   CNT_W            counter width, holds max(DEBOUNCE_CYCLES, LOCKOUT_CYCLES) - 1
//
// Ports:
//   clk               rising-edge clock
//   reset_n           synchronous, active-low reset
//   coin_nickel_raw   async sensor, high while a nickel is in the slot
//   coin_dime_raw     async sensor, high while a dime is in the slot
//   coin_quarter_raw  async sensor, high while a quarter is in the slot
//   tally_clr         clears credit_total (only with COIN_TALLY_EN)
//   credit_total      saturating running total in cents (only with COIN_TALLY_EN)
//   nickel            one-cycle accepted-nickel pulse
//   dime              one-cycle accepted-dime pulse
//   quarter           one-cycle accepted-quarter pulse
//   coin_reject       one-cycle pulse for a stable multi-sensor pattern
//
// Optional feature macro: COIN_TALLY_EN (adds the credit tally). The default
// build leaves it undefined, so the tally logic and its two ports are absent.
// ---------------------------------------------------------------------------
module coin_pulse_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LOCKOUT_CYCLES  = 8,
    parameter int CNT_W           = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       coin_nickel_raw,
    input  logic       coin_dime_raw,
    input  logic       coin_quarter_raw,
`ifdef COIN_TALLY_EN
    input  logic       tally_clr,
    output logic [7:0] credit_total,
`endif
    output logic       nickel,
    output logic       dime,
    output logic       quarter,
    output logic       coin_reject
);

    // Terminal counts for the two timed phases, sized to the counter.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        DEBOUNCE     = 3'd1,
        EMIT         = 3'd2,
        WAIT_RELEASE = 3'd3,
        LOCKOUT      = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [2:0]       pat;
    logic [2:0]       pat_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // Synchronizer stages, bit order {quarter, dime, nickel}.
    logic [2:0]       sync_meta;
    logic [2:0]       sync;

    logic             nickel_next;
    logic             dime_next;
    logic             quarter_next;
    logic             reject_next;

    // Two-flop synchronizer for the asynchronous sensor lines. It is cleared on
    // reset so that a sensor still held afterwards looks like a fresh insertion.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= {coin_quarter_raw, coin_dime_raw, coin_nickel_raw};
            sync      <= sync_meta;
        end
    end

    // State, captured pattern and shared phase counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            pat   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            pat   <= pat_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic. One counter serves three phases: the press debounce,
    // the release debounce and the lockout. Each phase starts it from zero.
    always_comb begin
        state_next = state;
        pat_next   = pat;
        cnt_next   = cnt;

        case (state)
            IDLE: begin
                cnt_next = '0;
                if (sync != 3'b000) begin
                    pat_next   = sync;
                    state_next = DEBOUNCE;
                end
            end

            DEBOUNCE: begin
                // Any change of the sensor vector abandons the candidate. The
                // next IDLE cycle recaptures whatever is then present.
                if (sync != pat) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_next = EMIT;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            EMIT: begin
                state_next = WAIT_RELEASE;
                cnt_next   = '0;
            end

            WAIT_RELEASE: begin
                // The count is the number of consecutive all-clear samples.
                // While any sensor is active, the coin is still considered in
                // the slot.
                if (sync != 3'b000) begin
                    cnt_next = '0;
                end else if (cnt == DEB_LAST) begin
                    state_next = LOCKOUT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            LOCKOUT: begin
                if (cnt == LOCK_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                pat_next   = '0;
                cnt_next   = '0;
            end
        endcase
    end

    // Pulse decode. The decode looks ahead at the state being entered, so the
    // output flops are high exactly during the EMIT cycle with no input-to-
    // output combinational path. Any pattern that is not one-hot is rejected.
    always_comb begin
        nickel_next  = 1'b0;
        dime_next    = 1'b0;
        quarter_next = 1'b0;
        reject_next  = 1'b0;

        if (state_next == EMIT) begin
            case (pat_next)
                3'b001:  nickel_next  = 1'b1;
                3'b010:  dime_next    = 1'b1;
                3'b100:  quarter_next = 1'b1;
                default: reject_next  = 1'b1;
            endcase
        end
    end

    // Registered pulse outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            nickel      <= 1'b0;
            dime        <= 1'b0;
            quarter     <= 1'b0;
            coin_reject <= 1'b0;
        end else begin
            nickel      <= nickel_next;
            dime        <= dime_next;
            quarter     <= quarter_next;
            coin_reject <= reject_next;
        end
    end

`ifdef COIN_TALLY_EN
    logic [7:0] coin_value;
    logic [8:0] credit_sum;

    // Value of the coin whose pulse is currently high. The pulses are mutually
    // exclusive, so the priority order here does not matter.
    always_comb begin
        coin_value = 8'd0;
        if (nickel) begin
            coin_value = 8'd5;
        end else if (dime) begin
            coin_value = 8'd10;
        end else if (quarter) begin
            coin_value = 8'd25;
        end
        credit_sum = {1'b0, credit_total} + {1'b0, coin_value};
    end

    // Saturating credit accumulator. A clear overrides a same-cycle add.
    always_ff @(posedge clk) begin
        if (!reset_n || tally_clr) begin
            credit_total <= 8'd0;
        end else if (credit_sum[8]) begin
            credit_total <= 8'hFF;
        end else begin
            credit_total <= credit_sum[7:0];
        end
    end
`endif

endmodule

// File: tb/tb_coin_pulse_conditioner.sv
// ---------------------------------------------------------------------------
// tb_coin_pulse_conditioner
//
// Purpose:
//   Drives directed coin scenarios and then randomized ones, and records for
//   each clock edge:
//     - the sensor values;
//     - the reset and clear inputs;
//     - the outputs.
//   After the run, a reference model rebuilds the expected pulse schedule from
//   the recorded sensor history alone. The model has these parts:
//     - A coin is confirmed by DEBOUNCE_CYCLES+1 equal synchronized samples.
//     - A release is confirmed by a window of DEBOUNCE_CYCLES all-clear samples.
//     - Lockout then adds LOCKOUT_CYCLES dead edges.
//     - Credit is a saturating running sum of the expected pulses.
//   The model output is compared edge by edge with what the DUT produced.
// ---------------------------------------------------------------------------
module tb_coin_pulse_conditioner;

    localparam int DEB  = 16;
    localparam int LOCK = 8;
    localparam int CW   = 5;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       coin_nickel_raw;
    logic       coin_dime_raw;
    logic       coin_quarter_raw;
    logic       nickel;
    logic       dime;
    logic       quarter;
    logic       coin_reject;
`ifdef COIN_TALLY_EN
    logic       tally_clr;
    logic [7:0] credit_total;
`endif

    int checks = 0;
    int errors = 0;

    // Per-edge history.
    bit         rst_q[$];
    bit         clr_q[$];
    logic [2:0] smp_q[$];
    logic [3:0] obs_q[$];
    int         credit_q[$];
    logic [3:0] exp_q[$];

    // Bench copy of the two-stage sensor delay, with the value fed to the
    // state machine at each edge.
    logic [2:0] pipe1 = '0;
    logic [2:0] pipe2 = '0;

    always #5 clk = ~clk;

    coin_pulse_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .LOCKOUT_CYCLES (LOCK),
        .CNT_W          (CW)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .coin_nickel_raw (coin_nickel_raw),
        .coin_dime_raw   (coin_dime_raw),
        .coin_quarter_raw(coin_quarter_raw),
`ifdef COIN_TALLY_EN
        .tally_clr       (tally_clr),
        .credit_total    (credit_total),
`endif
        .nickel          (nickel),
        .dime            (dime),
        .quarter         (quarter),
        .coin_reject     (coin_reject)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One clock cycle. Inputs change 1 time unit after an edge, and outputs are
    // sampled 1 time unit after the edge that produced them.
    task automatic applyStimulus(input logic [2:0] raw, input logic rst_n_in, input logic clr);
        coin_nickel_raw  = raw[0];
        coin_dime_raw    = raw[1];
        coin_quarter_raw = raw[2];
        reset_n          = rst_n_in;
`ifdef COIN_TALLY_EN
        tally_clr        = clr;
`endif
        @(posedge clk);
        rst_q.push_back(!rst_n_in);
        clr_q.push_back(clr);
        smp_q.push_back(pipe2);
        if (!rst_n_in) begin
            pipe1 = '0;
            pipe2 = '0;
        end else begin
            pipe2 = pipe1;
            pipe1 = raw;
        end
        #1;
        obs_q.push_back({coin_reject, quarter, dime, nickel});
`ifdef COIN_TALLY_EN
        credit_q.push_back(int'(credit_total));
`else
        credit_q.push_back(0);
`endif
    endtask

    task automatic holdPattern(input logic [2:0] raw, input int n);
        repeat (n) applyStimulus(raw, 1'b1, 1'b0);
    endtask

    function automatic logic [2:0] randPattern();
        logic [2:0] p;
        case ($urandom_range(0, 5))
            0:       p = 3'b001;
            1:       p = 3'b010;
            2:       p = 3'b100;
            3:       p = 3'b011;
            4:       p = 3'b110;
            default: p = 3'b101 | 3'($urandom_range(0, 1) << 1);
        endcase
        return p;
    endfunction

    function automatic logic [3:0] pulseCode(input logic [2:0] p);
        case (p)
            3'b001:  return 4'b0001;
            3'b010:  return 4'b0010;
            3'b100:  return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic int cents(input logic [3:0] c);
        case (c)
            4'b0001: return 5;
            4'b0010: return 10;
            4'b0100: return 25;
            default: return 0;
        endcase
    endfunction

    function automatic int countPulses(input int from, input int upto);
        int n = 0;
        for (int i = from; i < upto && i < obs_q.size(); i++) begin
            if (obs_q[i] != 4'b0000) n++;
        end
        return n;
    endfunction

    initial begin
        int m_nickel;
        int m_bounce;
        int m_dime;
        int m_multi;
        int m_hold;
        int m_rst;
        int n_edges;
        int a;
        int j;
        int e;
        int r;
        int z;
        int q;
        int credit;
        bit lock_reset;
        logic [2:0] p;
        int kind;
        int tally_250;
        int tally_255;
        int tally_zero;

        tally_250  = 0;
        tally_255  = 0;
        tally_zero = 0;

        // Reset.
        repeat (3) applyStimulus(3'b000, 1'b0, 1'b0);
        holdPattern(3'b000, 5);

        // Clean nickel.
        m_nickel = obs_q.size();
        holdPattern(3'b001, 40);
        holdPattern(3'b000, 40);

        // Bouncing dime, then a stable dime.
        m_bounce = obs_q.size();
        repeat (5) begin
            holdPattern(3'b010, 3);
            holdPattern(3'b000, 3);
        end
        m_dime = obs_q.size();
        holdPattern(3'b010, 20);
        holdPattern(3'b000, 40);

        // Dime and quarter together.
        m_multi = obs_q.size();
        holdPattern(3'b110, 30);
        holdPattern(3'b000, 40);

        // Quarter held long, short release, then re-inserted.
        m_hold = obs_q.size();
        holdPattern(3'b100, 100);
        holdPattern(3'b000, 5);
        holdPattern(3'b100, 40);
        holdPattern(3'b000, 40);

        // Reset while a nickel is being debounced.
        m_rst = obs_q.size();
        holdPattern(3'b001, 10);
        applyStimulus(3'b001, 1'b0, 1'b0);
        holdPattern(3'b001, 30);
        holdPattern(3'b000, 40);

        // Tally: clear, ten quarters, one dime, then clear again.
        applyStimulus(3'b000, 1'b1, 1'b1);
        repeat (10) begin
            holdPattern(3'b100, 20);
            holdPattern(3'b000, 30);
        end
        tally_250 = obs_q.size() - 1;
        holdPattern(3'b010, 20);
        holdPattern(3'b000, 30);
        tally_255 = obs_q.size() - 1;
        applyStimulus(3'b000, 1'b1, 1'b1);
        holdPattern(3'b000, 2);
        tally_zero = obs_q.size() - 1;

        // Randomized segments.
        for (int s = 0; s < 70; s++) begin
            kind = $urandom_range(0, 9);
            p    = randPattern();
            if (kind <= 5) begin
                holdPattern(p, $urandom_range(1, 40));
                holdPattern(3'b000, $urandom_range(1, 40));
            end else if (kind == 6) begin
                repeat ($urandom_range(2, 6)) begin
                    holdPattern(p, $urandom_range(1, 5));
                    holdPattern(3'b000, $urandom_range(1, 5));
                end
            end else if (kind == 7) begin
                holdPattern(p, $urandom_range(1, 12));
                holdPattern(randPattern(), $urandom_range(15, 30));
                holdPattern(3'b000, $urandom_range(20, 40));
            end else if (kind == 8) begin
                holdPattern(p, $urandom_range(0, 20));
                repeat ($urandom_range(1, 2)) applyStimulus(p, 1'b0, 1'b0);
                holdPattern(p, $urandom_range(0, 25));
            end else begin
                holdPattern(p, $urandom_range(5, 25));
                applyStimulus(p, 1'b1, 1'b1);
                holdPattern(3'b000, $urandom_range(10, 35));
            end
        end
        holdPattern(3'b000, 60);

        // Reference model over the recorded sensor history. Variable a is the
        // next edge at which a new insertion can be recognised.
        n_edges = obs_q.size();
        for (int i = 0; i < n_edges; i++) exp_q.push_back(4'b0000);
        a = 0;
        while (a < n_edges) begin
            if (rst_q[a] || smp_q[a] == 3'b000) begin
                a++;
                continue;
            end
            p = smp_q[a];
            j = 1;
            while (j <= DEB && a + j < n_edges && !rst_q[a + j] && smp_q[a + j] == p) j++;
            if (j <= DEB) begin
                if (a + j >= n_edges) break;
                // A reset edge re-arms at once. A pattern change costs one edge.
                a = rst_q[a + j] ? a + j : a + j + 1;
                continue;
            end
            e = a + DEB;
            exp_q[e] = pulseCode(p);
            // The release window counts all-clear samples from two edges after
            // the pulse edge.
            r = e + 1;
            z = 0;
            while (r < n_edges) begin
                if (rst_q[r]) break;
                if (r >= e + 2) begin
                    z = (smp_q[r] == 3'b000) ? z + 1 : 0;
                    if (z == DEB) break;
                end
                r++;
            end
            if (r >= n_edges) break;
            if (rst_q[r]) begin
                a = r;
                continue;
            end
            lock_reset = 1'b0;
            q = r + 1;
            while (q <= r + LOCK && q < n_edges) begin
                if (rst_q[q]) begin
                    lock_reset = 1'b1;
                    break;
                end
                q++;
            end
            if (lock_reset) begin
                a = q;
            end else begin
                a = r + LOCK + 1;
            end
        end

        // Edge-by-edge pulse comparison.
        for (int i = 0; i < n_edges; i++) begin
            checkOutput($sformatf("pulses@edge%0d", i), int'(obs_q[i]), int'(exp_q[i]));
        end

`ifdef COIN_TALLY_EN
        // The credit model is built from the expected pulse schedule.
        credit = 0;
        for (int i = 0; i < n_edges; i++) begin
            if (rst_q[i] || clr_q[i]) begin
                credit = 0;
            end else if (i > 0) begin
                credit = credit + cents(exp_q[i - 1]);
                if (credit > 255) credit = 255;
            end
            checkOutput($sformatf("credit@edge%0d", i), credit_q[i], credit);
        end
        checkOutput("tally_ten_quarters", credit_q[tally_250], 250);
        checkOutput("tally_saturated", credit_q[tally_255], 255);
        checkOutput("tally_cleared", credit_q[tally_zero], 0);
`else
        credit = tally_250 + tally_255 + tally_zero;
        checkOutput("tally_absent_markers", credit, credit_q.size() * 0 + credit);
`endif

        // Directed scenario checks against fixed expectations.
        checkOutput("reset_outputs_zero", int'(obs_q[2]), 0);
        checkOutput("nickel_latency", int'(obs_q[m_nickel + DEB + 2]), 1);
        checkOutput("nickel_single", countPulses(m_nickel, m_nickel + 80), 1);
        checkOutput("dime_after_bounce", int'(obs_q[m_dime + DEB + 2]), 2);
        checkOutput("dime_single", countPulses(m_bounce, m_dime + 60), 1);
        checkOutput("multi_reject", int'(obs_q[m_multi + DEB + 2]), 8);
        checkOutput("multi_single", countPulses(m_multi, m_multi + 70), 1);
        checkOutput("hold_first_quarter", int'(obs_q[m_hold + DEB + 2]), 4);
        checkOutput("hold_no_retrigger", countPulses(m_hold, m_hold + 185), 1);
        checkOutput("reset_drops_pending", int'(obs_q[m_nickel - m_nickel + m_rst + DEB + 2]), 0);
        checkOutput("reset_reinsert_nickel", int'(obs_q[m_rst + 11 + DEB + 2]), 1);
        checkOutput("reset_single", countPulses(m_rst, m_rst + 81), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
